// File: rtl/processing_unit_neo_mc.sv
// Multi-channel NEO spike detector with per-channel refractory suppression and an event FIFO.
// Define PU_DROP_COUNT_EN to build the saturating counter of events lost to a full FIFO.
module processing_unit_neo_mc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned REFRACT    = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [3:0]              sample_chan,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [2*DATA_WIDTH-1:0] threshold,
  output logic                    spike_detection,
  output logic [31:0]             event_out,
  output logic                    event_valid,
  input  logic                    event_ready,
  output logic [15:0]             drop_count
);

  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned NCH = 2 ** CW;
  localparam int unsigned RW  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Stage 0: accept sample, read history, form products
  // ---------------------------------------------------------------------------
  logic                         accept;
  logic [CW-1:0]                ch_s0;
  logic [27:0]                  ts_q, ts_d;
  logic signed [DATA_WIDTH-1:0] x_s0, x1_s0, x2_s0;
  logic signed [PW-1:0]         sq_d, cr_d;

  logic signed [DATA_WIDTH-1:0] x1_q [NCH];
  logic signed [DATA_WIDTH-1:0] x2_q [NCH];
  logic [1:0]                   warm_q [NCH];
  logic [RW-1:0]                rcnt_q [NCH];

  assign accept = sample_valid && (32'(sample_chan) < CHANNELS);
  assign ch_s0  = sample_chan[CW-1:0];
  assign x_s0   = $signed(data_in);
  assign x1_s0  = x1_q[ch_s0];
  assign x2_s0  = x2_q[ch_s0];
  assign sq_d   = x1_s0 * x1_s0;
  assign cr_d   = x_s0 * x2_s0;
  assign ts_d   = ts_q + 28'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  // Sample history advances on accept so a back-to-back sample sees it next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
      end
    end else if (accept) begin
      x1_q[ch_s0] <= x_s0;
      x2_q[ch_s0] <= x1_q[ch_s0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered products, compare, warm-up and refractory bookkeeping
  // ---------------------------------------------------------------------------
  logic                 s1_vld_q;
  logic [3:0]           s1_chan_q;
  logic [27:0]          s1_ts_q;
  logic signed [PW-1:0] sq_q, cr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_chan_q <= '0;
      s1_ts_q   <= '0;
      sq_q      <= '0;
      cr_q      <= '0;
    end else begin
      s1_vld_q  <= accept;
      s1_chan_q <= sample_chan;
      s1_ts_q   <= ts_q;
      sq_q      <= sq_d;
      cr_q      <= cr_d;
    end
  end

  logic [CW-1:0]      ch_s1;
  logic signed [PW:0] psi, thr;
  logic [1:0]         warm_cur, warm_nxt;
  logic [RW-1:0]      rcnt_cur, rcnt_nxt;
  logic               det_s1;

  assign ch_s1    = s1_chan_q[CW-1:0];
  assign psi      = {sq_q[PW-1], sq_q} - {cr_q[PW-1], cr_q};
  assign thr      = $signed({1'b0, threshold});
  assign warm_cur = warm_q[ch_s1];
  assign rcnt_cur = rcnt_q[ch_s1];
  assign det_s1   = s1_vld_q && (psi > thr) && (warm_cur == 2'd2) && (rcnt_cur == '0);

  always_comb begin
    warm_nxt = (warm_cur == 2'd2) ? 2'd2 : warm_cur + 2'd1;
    rcnt_nxt = rcnt_cur;
    if (det_s1) begin
      rcnt_nxt = RW'(REFRACT);
    end else if (rcnt_cur != '0) begin
      rcnt_nxt = rcnt_cur - RW'(1);
    end
  end

  // Refractory state is owned here so the next same-channel sample reads it one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        warm_q[i] <= '0;
        rcnt_q[i] <= '0;
      end
    end else if (s1_vld_q) begin
      warm_q[ch_s1] <= warm_nxt;
      rcnt_q[ch_s1] <= rcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: detection pulse and FIFO write
  // ---------------------------------------------------------------------------
  logic        spike_q;
  logic [31:0] ev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= 1'b0;
      ev_q    <= '0;
    end else begin
      spike_q <= det_s1;
      ev_q    <= {s1_chan_q, s1_ts_q};
    end
  end

  assign spike_detection = spike_q;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        full, empty, pop, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && event_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign push  = spike_q && (!full || pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= ev_q;
    end
  end

  assign event_valid = !empty;
  assign event_out   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

`ifdef PU_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (spike_q && !push && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule
